// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and writes them to consecutive word addresses.
// Latency: one cycle from accept to write; backpressure: in_ready is high only while a session is loading.
module instr_encoder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [23:0]       src2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [7:0]        remain_q, remain_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              accept;
  logic              idle_start;
  logic [31:0]       enc_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && count != 8'd0) state_d = LOAD;
      LOAD:    if (accept && remain_q == 8'd1) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q != IDLE);
  end

  assign accept     = in_valid && in_ready;
  assign idle_start = (state_q == IDLE) && start;

  // Branches carry a 24-bit offset and keep only the top two funct bits.
  assign enc_word = op[1] ? {cond, op, funct[5:4], src2}
                          : {cond, op, funct, rn, rd, src2[11:0]};

  always_comb begin
    remain_d    = remain_q;
    next_addr_d = next_addr_q;
    err_d       = err_q;
    if (idle_start) begin
      err_d       = 1'b0;
      remain_d    = count;
      next_addr_d = base_addr;
    end else if (accept) begin
      remain_d    = remain_q - 8'd1;
      next_addr_d = next_addr_q + ADDR_W'(4);
      if (op == 2'b11) err_d = 1'b1;
    end
    mem_we_d = accept && (op != 2'b11);
    done_d   = (state_q == FLUSH) || (idle_start && count == 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remain_q    <= '0;
      next_addr_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      remain_q    <= remain_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      done_q      <= done_d;
      mem_we_q    <= mem_we_d;
      if (mem_we_d) begin
        mem_addr_q  <= next_addr_q;
        mem_wdata_q <= enc_word;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a session-level reference model.
module tb_instr_encoder;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] src2;
  } item_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  count;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [23:0] src2;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .cond(cond), .op(op), .funct(funct),
    .rn(rn), .rd(rd), .src2(src2), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a session is either inactive, loading (rem>0) or flushing (rem==0).
  bit          m_busy;
  int          m_rem;
  int          m_k;
  logic [31:0] m_base;
  bit          m_err;

  item_t       items[$];
  logic [31:0] obs_a[$];
  logic [31:0] obs_d[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [3:0] n, input logic [3:0] d, input logic [23:0] s);
    item_t it;
    it.cond = c; it.op = o; it.funct = f; it.rn = n; it.rd = d; it.src2 = s;
    return it;
  endfunction

  function automatic logic [31:0] encode(input item_t it);
    case (it.op)
      2'b00, 2'b01: return {it.cond, it.op, it.funct, it.rn, it.rd, it.src2[11:0]};
      2'b10:        return {it.cond, it.op, it.funct[5:4], it.src2};
      default:      return 32'h0;
    endcase
  endfunction

  task automatic drive_item(input item_t it);
    cond = it.cond; op = it.op; funct = it.funct; rn = it.rn; rd = it.rd; src2 = it.src2;
  endtask

  task automatic model_reset();
    m_busy = 0; m_rem = 0; m_k = 0; m_base = '0; m_err = 0;
  endtask

  // Advance one clock with the current inputs and compare every output against the model.
  task automatic cycle();
    bit          idle, loading, flushing, acc, e_we, e_done;
    logic [31:0] e_addr, e_wd;
    idle     = !m_busy;
    loading  = m_busy && m_rem > 0;
    flushing = m_busy && m_rem == 0;
    acc      = in_valid && loading;
    e_we     = acc && op != 2'b11;
    e_addr   = m_base + 32'(4 * m_k);
    e_wd     = encode(mk(cond, op, funct, rn, rd, src2));
    e_done   = flushing || (idle && start && count == 8'd0);
    if (idle && start) begin
      m_err = 0;
      if (count != 8'd0) begin
        m_busy = 1; m_rem = int'(count); m_k = 0; m_base = base_addr;
      end
    end else if (acc) begin
      if (op == 2'b11) m_err = 1;
      m_k++;
      m_rem--;
    end else if (flushing) begin
      m_busy = 0;
    end
    @(negedge clk);
    check_eq("mem_we", 32'(mem_we), 32'(e_we));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("in_ready", 32'(in_ready), 32'(m_busy && m_rem > 0));
    check_eq("err", 32'(err), 32'(m_err));
    if (e_we) begin
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_wdata", mem_wdata, e_wd);
    end
    if (mem_we) begin
      obs_a.push_back(mem_addr);
      obs_d.push_back(mem_wdata);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [7:0] c);
    obs_a.delete();
    obs_d.delete();
    start = 1; base_addr = b; count = c; in_valid = 0;
    cycle();
    start = 0; base_addr = $urandom; count = 8'($urandom);
  endtask

  task automatic run_items(input int gap, input bit rnd);
    foreach (items[i]) begin
      int  g;
      int  waited;
      bit  acc_now;
      g = rnd ? int'($urandom_range(0, 2)) : ((i > 0) ? gap : 0);
      repeat (g) begin
        in_valid = 0;
        drive_item(item_t'({$urandom, $urandom}));
        start = rnd && ($urandom_range(0, 3) == 0);
        base_addr = $urandom; count = 8'($urandom);
        cycle();
        start = 0;
      end
      drive_item(items[i]);
      in_valid = 1;
      waited = 0;
      do begin
        acc_now = m_busy && m_rem > 0;
        cycle();
        waited++;
      end while (!acc_now && waited < 20);
      check_eq("accept_seen", 32'(acc_now), 32'd1);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    repeat (3) cycle();
  endtask

  item_t add_i, ldr_i, br_i, bad_i;

  initial begin
    add_i = mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005);
    ldr_i = mk(4'hE, 2'b01, 6'b011001, 4'd1, 4'd0, 24'h000004);
    br_i  = mk(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 24'hFFFFFE);
    bad_i = mk(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, 24'h000000);

    reset_n = 0; start = 0; base_addr = '0; count = '0; in_valid = 0;
    drive_item('0);
    model_reset();
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_mem_we", 32'(mem_we), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Single ADD
    do_start(32'h100, 8'd1);
    items = '{add_i};
    run_items(0, 0);
    drain();
    check_eq("add_nwr", 32'(obs_a.size()), 1);
    check_eq("add_addr", obs_a[0], 32'h100);
    check_eq("add_data", obs_d[0], 32'hE2821005);

    // Back-to-back ADD, LDR, B
    do_start(32'h0, 8'd3);
    items = '{add_i, ldr_i, br_i};
    run_items(0, 0);
    drain();
    check_eq("b2b_nwr", 32'(obs_a.size()), 3);
    check_eq("b2b_a0", obs_a[0], 32'h0);
    check_eq("b2b_d0", obs_d[0], 32'hE2821005);
    check_eq("b2b_a1", obs_a[1], 32'h4);
    check_eq("b2b_d1", obs_d[1], 32'hE5910004);
    check_eq("b2b_a2", obs_a[2], 32'h8);
    check_eq("b2b_d2", obs_d[2], 32'hEAFFFFFE);

    // Stall gap of 3 cycles
    do_start(32'h0, 8'd2);
    items = '{add_i, ldr_i};
    run_items(3, 0);
    drain();
    check_eq("gap_nwr", 32'(obs_a.size()), 2);
    check_eq("gap_a0", obs_a[0], 32'h0);
    check_eq("gap_a1", obs_a[1], 32'h4);

    // Illegal op then a legal one; err sticks until next start
    do_start(32'h0, 8'd2);
    items = '{bad_i, add_i};
    run_items(0, 0);
    drain();
    check_eq("ill_nwr", 32'(obs_a.size()), 1);
    check_eq("ill_a0", obs_a[0], 32'h4);
    check_eq("ill_err_sticky", 32'(err), 1);
    do_start(32'h0, 8'd0);
    check_eq("zero_done", 32'(done), 1);
    check_eq("err_cleared", 32'(err), 0);
    drain();

    // Start during LOAD is ignored
    do_start(32'h200, 8'd2);
    start = 1; base_addr = 32'h900; count = 8'd5;
    cycle();
    start = 0;
    items = '{ldr_i, br_i};
    run_items(0, 0);
    drain();
    check_eq("ign_a0", obs_a[0], 32'h200);
    check_eq("ign_a1", obs_a[1], 32'h204);

    // Asynchronous reset mid-session
    do_start(32'h0, 8'd3);
    drive_item(add_i);
    in_valid = 1;
    cycle();
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    check_eq("ares_mem_we", 32'(mem_we), 0);
    check_eq("ares_busy", 32'(busy), 0);
    check_eq("ares_in_ready", 32'(in_ready), 0);
    check_eq("ares_mem_addr", mem_addr, 0);
    check_eq("ares_mem_wdata", mem_wdata, 0);
    check_eq("ares_done", 32'(done), 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    drain();
    do_start(32'hFFFFFFFC, 8'd2);
    items = '{add_i, br_i};
    run_items(0, 0);
    drain();
    check_eq("wrap_a0", obs_a[0], 32'hFFFFFFFC);
    check_eq("wrap_a1", obs_a[1], 32'h00000000);

    // Random sessions
    for (int s = 0; s < 40; s++) begin
      int n;
      n = int'($urandom_range(0, 6));
      do_start($urandom, 8'(n));
      items.delete();
      for (int j = 0; j < n; j++) items.push_back(item_t'({$urandom, $urandom}));
      run_items(0, 1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the memory write address.
REQ-002 SHALL have ports as listed in REQ-003..REQ-020; one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a load session, sampled in IDLE only.
REQ-006 base_addr  input  ADDR_W  byte address of the first instruction word, sampled with start.
REQ-007 count  input  8  number of instructions in the session, sampled with start.
REQ-008 in_valid  input  1  instruction fields valid.
REQ-009 in_ready  output  1  encoder accepts fields this cycle.
REQ-010 cond  input  4  condition field.
REQ-011 op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-012 funct  input  6  function field.
REQ-013 rn  input  4  first source register.
REQ-014 rd  input  4  destination register.
REQ-015 src2  input  24  immediate or offset field.
REQ-016 mem_we  output  1  instruction-memory write strobe.
REQ-017 mem_addr  output  ADDR_W  write byte address.
REQ-018 mem_wdata  output  32  encoded instruction word.
REQ-019 busy  output  1  session in progress (state is not IDLE).
REQ-020 done  output  1  one-cycle session-complete pulse; err  output  1  sticky illegal-op flag.

Function
REQ-021 SHALL implement the FSM states IDLE, LOAD and FLUSH.
REQ-022 IDLE: on start with count!=0, SHALL latch base_addr and count, clear err, and go to LOAD.
REQ-023 IDLE: on start with count==0, SHALL pulse done on the next cycle, clear err, and stay in IDLE.
REQ-024 in_ready SHALL be 1 only in LOAD, and SHALL be 0 in IDLE and FLUSH.
REQ-025 An accept SHALL occur when in_valid and in_ready are both 1; each accept SHALL decrement the remaining counter.
REQ-026 op 00/01 SHALL encode as mem_wdata = {cond, op, funct, rn, rd, src2[11:0]}.
REQ-027 op 10 SHALL encode as mem_wdata = {cond, op, funct[5:4], src2[23:0]}.
REQ-028 op 11 SHALL count as accepted, SHALL produce no write (mem_we stays 0 for that slot), SHALL still advance the address, and SHALL set err.
REQ-029 Write latency SHALL be one cycle: an accept at cycle t SHALL drive the registered mem_we/mem_addr/mem_wdata at t+1, and SHALL support back-to-back accepts (one per cycle).
REQ-030 The k-th accept of a session (k from 0) SHALL use mem_addr = base_addr + 4*k, with mod 2^ADDR_W wrap-around and no error on wrap.
REQ-031 The accept that brings the remaining counter to 0 SHALL move LOAD to FLUSH; during FLUSH the last write is visible.
REQ-032 FLUSH SHALL go to IDLE unconditionally, with done=1 for exactly the first IDLE cycle.
REQ-033 mem_we SHALL be 0 in every cycle not following an accept of op 00/01/10.
REQ-034 start SHALL be ignored while busy=1.
REQ-035 A deasserted in_valid in LOAD SHALL stall the session with no write and no address advance.
REQ-036 err SHALL hold until the next start or reset.

Reset
REQ-037 reset_n=0 SHALL force IDLE and clear in_ready, mem_we, mem_addr, mem_wdata, busy, done, err and the internal counter immediately, without waiting for clk.
REQ-038 Reset mid-session SHALL abandon remaining writes and SHALL NOT produce a done pulse; the first start after release SHALL begin a fresh session.

Verification
REQ-039 start, base=0x100, count=1; ADD: cond=1110, op=00, funct=101000, rn=2, rd=1, src2=0x005 -> mem_we=1, addr=0x100, wdata=0xE2821005 one cycle after accept; done two cycles after accept.
REQ-040 count=3, back-to-back ADD, then LDR (op=01, funct=011001, rn=1, rd=0, src2=0x004), then B (op=10, funct=100000, src2=0xFFFFFE), base=0x0 -> writes on 3 consecutive cycles: 0x0/0xE2821005, 0x4/0xE5910004, 0x8/0xEAFFFFFE; done once.
REQ-041 count=2 with in_valid low for 3 cycles between items -> no writes during the gap, addresses 0x0 then 0x4, busy stays 1 until the done cycle.
REQ-042 count=2, first item op=11 -> no write at 0x0, second item written at 0x4, err=1 after done, err=0 after the next start.
REQ-043 count=0 start -> done pulse next cycle, busy never 1; start asserted during LOAD -> ignored, base unchanged.
REQ-044 reset_n low mid-session after 1 of 3 accepts -> all outputs 0 asynchronously, no done pulse; base=0xFFFFFFFC, count=2 after release -> addresses 0xFFFFFFFC then 0x00000000.
